ram8_arbiter: RTL and testbench

RAM8_ARBITER -- requirements
Module: ram8_arbiter

---
 rtl/ram8_arb_pkg.sv | 25 ++
 rtl/ram8.sv | 23 ++
 rtl/ram8_arbiter.sv | 114 +++++++++++
 tb/tb_ram8_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ram8_arb_pkg.sv
// Shared constants, FSM encoding and requester ids for the two-port RAM arbiter.
// Also holds the fixed-priority tie-break used when both requesters ask at once.
package ram8_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // A lone requester always wins; a tie goes to whoever currently holds priority.
  function automatic logic pickWinner(input logic aReq, input logic bReq, input logic prio);
    if (aReq && bReq) begin
      return prio;
    end
    return aReq ? ID_A : ID_B;
  endfunction

endpackage

// File: rtl/ram8.sv
// 8x16 storage: synchronous write, combinational read.
// Contents are deliberately left unreset.
module ram8
  import ram8_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter granting two requesters access to a single ram8 instance.
// Each access walks IDLE -> ACCESS -> RESP, giving one access every three cycles.
module ram8_arbiter
  import ram8_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_id;
  logic              r_we;
  logic              r_prio;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_ramRdata;
  logic              w_anyReq;
  logic              w_winner;
  logic              w_ramLoad;

  assign w_anyReq = a_req | b_req;
  assign w_winner = pickWinner(a_req, b_req, r_prio);
  assign rdata    = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_ramLoad   = 1'b0;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_anyReq) begin
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        w_ramLoad   = r_we;
        w_nextState = RESP;
      end
      RESP: begin
        a_ack       = (r_id == ID_A);
        b_ack       = (r_id == ID_B);
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Reset returns to IDLE, so an interrupted ACCESS never reaches its committing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= ID_A;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_prio  <= ID_A;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_id    <= w_winner;
            r_we    <= (w_winner == ID_B) ? b_we    : a_we;
            r_addr  <= (w_winner == ID_B) ? b_addr  : a_addr;
            r_wdata <= (w_winner == ID_B) ? b_wdata : a_wdata;
          end
        end
        ACCESS: begin
          r_rdata <= r_we ? r_wdata : w_ramRdata;
        end
        RESP: begin
          r_prio <= ~r_id;
        end
        default: begin
        end
      endcase
    end
  end

  ram8 u_ram (
    .i_clk   (clk),
    .i_we    (w_ramLoad),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ramRdata)
  );

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed self-checking bench for ram8_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
module tb_ram8_arbiter;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        a_req   = 1'b0;
  logic        a_we    = 1'b0;
  logic [2:0]  a_addr  = 3'd0;
  logic [15:0] a_wdata = 16'h0000;
  logic        a_ack;
  logic        b_req   = 1'b0;
  logic        b_we    = 1'b0;
  logic [2:0]  b_addr  = 3'd0;
  logic [15:0] b_wdata = 16'h0000;
  logic        b_ack;
  logic [15:0] rdata;
  logic        busy;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  ram8_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_ack   (a_ack),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_ack   (b_ack),
    .rdata   (rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isB, input logic req, input logic we,
                               input logic [2:0] addr, input logic [15:0] wdata);
    if (isB) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // Called just after a rising edge with the arbiter idle; the request is sampled
  // at the next edge and the ack must appear exactly in the third sampled cycle.
  task automatic serve(input string tag, input logic isB, input logic we,
                       input logic [2:0] addr, input logic [15:0] wdata, input logic [15:0] expRdata);
    applyStimulus(isB, 1'b1, we, addr, wdata);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c%0d own_ack", tag, c), {15'b0, isB ? b_ack : a_ack}, {15'b0, c == 2});
      checkOutput($sformatf("%s c%0d other_ack", tag, c), {15'b0, isB ? a_ack : b_ack}, 16'h0000);
      checkOutput($sformatf("%s c%0d busy", tag, c), {15'b0, busy}, {15'b0, c != 0});
      if (c < 2) @(posedge clk);
    end
    checkOutput($sformatf("%s rdata", tag), rdata, expRdata);
    @(posedge clk);
    #1;
    applyStimulus(isB, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    logic [15:0] expSeq [4];
    logic [15:0] val;
    logic [2:0]  addr;
    expSeq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", {15'b0, busy}, 16'h0000);
    checkOutput("reset a_ack", {15'b0, a_ack}, 16'h0000);
    checkOutput("reset b_ack", {15'b0, b_ack}, 16'h0000);
    checkOutput("reset rdata", rdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first cycle a_ack", {15'b0, a_ack}, 16'h0000);
    checkOutput("first cycle busy", {15'b0, busy}, 16'h0000);
    @(posedge clk);
    #1;

    serve("A write5", 1'b0, 1'b1, 3'd5, 16'hBEEF, 16'hBEEF);
    serve("B read5", 1'b1, 1'b0, 3'd5, 16'h0000, 16'hBEEF);

    // Both requesters keep asking from reset: grants must alternate A, B, A, B.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 16'h1111);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 16'h2222);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("alt c%0d a_ack", c), {15'b0, a_ack}, {15'b0, (c % 6) == 2});
      checkOutput($sformatf("alt c%0d b_ack", c), {15'b0, b_ack}, {15'b0, (c % 6) == 5});
      if ((c % 3) == 2) checkOutput($sformatf("alt c%0d rdata", c), rdata, expSeq[c / 3]);
      @(posedge clk);
      #1;
      if (c == 2)  applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 16'h3333);
      if (c == 5)  applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 16'h4444);
      if (c == 8)  applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
      if (c == 11) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000);
    end
    serve("readback addr0", 1'b1, 1'b0, 3'd0, 16'h0000, 16'h1111);
    serve("readback addr3", 1'b0, 1'b0, 3'd3, 16'h0000, 16'h4444);

    // Reset during ACCESS must drop the pending write and its ack.
    serve("A write7 CAFE", 1'b0, 1'b1, 3'd7, 16'hCAFE, 16'hCAFE);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, 16'h00FF);
    @(posedge clk);
    #2;
    checkOutput("abort pre busy", {15'b0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {15'b0, busy}, 16'h0000);
    checkOutput("abort a_ack", {15'b0, a_ack}, 16'h0000);
    checkOutput("abort rdata", rdata, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort after a_ack", {15'b0, a_ack}, 16'h0000);
    checkOutput("abort after busy", {15'b0, busy}, 16'h0000);
    @(posedge clk);
    #1;
    serve("read7 kept", 1'b0, 1'b0, 3'd7, 16'h0000, 16'hCAFE);
    serve("write7 0001", 1'b0, 1'b1, 3'd7, 16'h0001, 16'h0001);
    serve("read7 0001", 1'b0, 1'b0, 3'd7, 16'h0000, 16'h0001);

    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      val  = 16'hA5A5 ^ 16'(i);
      serve($sformatf("fill%0d", i), 1'b0, 1'b1, addr, val, val);
    end
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      val  = 16'hA5A5 ^ 16'(i);
      serve($sformatf("scan%0d", i), 1'b1, 1'b0, addr, 16'h0000, val);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
